// File: rtl/serial_frame_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_tx_if
//  Description : Word handshake and serial line bundle for serial_frame_tx.
//                The producer uses the master modport and the transmitter
//                uses the slave modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_frame_tx_if #(
    parameter int NUM_BITS = 8
);
    logic [NUM_BITS-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic                serial_out;
    logic                tx_busy;
    logic                tx_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, serial_out, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, serial_out, tx_busy, tx_done
    );
endinterface
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_tx
//  Description : Parallel-to-serial framed transmitter. Sends a start bit,
//                NUM_BITS data bits (MSB or LSB first), an optional even
//                parity bit and a stop bit, each held CLKS_PER_BIT clocks.
//                Idle line level is high.
//                Optional feature macro: SERIAL_TX_PARITY_EN (adds parity).
//  Revision    : 1.0  initial release
// ============================================================================
module serial_frame_tx #(
    parameter int NUM_BITS     = 8,
    parameter bit SHIFT_MSB    = 1'b1,
    parameter int CLKS_PER_BIT = 10
) (
    input  wire logic         clk,
    input  wire logic         rst,
    serial_frame_tx_if.slave  bus
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = $clog2(NUM_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(NUM_BITS - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_STOP   = 3'd3;
`ifdef SERIAL_TX_PARITY_EN
    localparam logic [2:0] c_S_PARITY = 3'd4;
`endif

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [NUM_BITS-1:0] r_shift;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_serial;
    logic                r_done;
`ifdef SERIAL_TX_PARITY_EN
    logic                r_parity;
`endif

    logic                w_bit_end;
    logic                w_out_bit;
    logic [NUM_BITS-1:0] w_shifted;
    logic                w_serial_nxt;
    logic                w_done_nxt;
    logic                w_load;
    logic                w_shift_en;
    logic                w_idx_inc;

    assign w_bit_end = (r_cnt == c_CNT_MAX);

    // The output end of the shift register is always the next data bit to send;
    // vacated positions fill with ones so the register drifts to the idle level.
    if (SHIFT_MSB) begin : g_msb_first
        assign w_out_bit = r_shift[NUM_BITS-1];
        assign w_shifted = {r_shift[NUM_BITS-2:0], 1'b1};
    end else begin : g_lsb_first
        assign w_out_bit = r_shift[0];
        assign w_shifted = {1'b1, r_shift[NUM_BITS-1:1]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and next-line-level decode; line changes only on bit boundaries
    always_comb begin
        w_next_state = r_state;
        w_serial_nxt = r_serial;
        w_done_nxt   = 1'b0;
        w_load       = 1'b0;
        w_shift_en   = 1'b0;
        w_idx_inc    = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (bus.tx_valid) begin
                    w_next_state = c_S_START;
                    w_serial_nxt = 1'b0;
                    w_load       = 1'b1;
                end
            end
            c_S_START: begin
                if (w_bit_end) begin
                    w_next_state = c_S_DATA;
                    w_serial_nxt = w_out_bit;
                    w_shift_en   = 1'b1;
                end
            end
            c_S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == c_IDX_MAX) begin
`ifdef SERIAL_TX_PARITY_EN
                        w_next_state = c_S_PARITY;
                        w_serial_nxt = r_parity;
`else
                        w_next_state = c_S_STOP;
                        w_serial_nxt = 1'b1;
`endif
                    end else begin
                        w_serial_nxt = w_out_bit;
                        w_shift_en   = 1'b1;
                        w_idx_inc    = 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            c_S_PARITY: begin
                if (w_bit_end) begin
                    w_next_state = c_S_STOP;
                    w_serial_nxt = 1'b1;
                end
            end
`endif
            c_S_STOP: begin
                if (w_bit_end) begin
                    w_next_state = c_S_IDLE;
                    w_serial_nxt = 1'b1;
                    w_done_nxt   = 1'b1;
                end
            end
            default: begin
                w_next_state = c_S_IDLE;
                w_serial_nxt = 1'b1;
            end
        endcase
    end

    // Datapath: shift register, bit-period counter, bit index, registered line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift  <= '1;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_serial <= 1'b1;
            r_done   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_serial <= w_serial_nxt;
            r_done   <= w_done_nxt;
            if (w_load) begin
                r_shift  <= bus.tx_data;
                r_cnt    <= '0;
                r_idx    <= '0;
`ifdef SERIAL_TX_PARITY_EN
                r_parity <= ^bus.tx_data;
`endif
            end else begin
                if (w_shift_en) begin
                    r_shift <= w_shifted;
                end
                if (w_idx_inc) begin
                    r_idx <= r_idx + 1'b1;
                end
                if (r_state != c_S_IDLE) begin
                    r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.tx_ready   = (r_state == c_S_IDLE);
    assign bus.tx_busy    = (r_state != c_S_IDLE);
    assign bus.serial_out = r_serial;
    assign bus.tx_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_frame_tx
//  Description : Self-checking bench for serial_frame_tx. Drives an MSB-first
//                and an LSB-first instance with identical stimulus and checks
//                both against a frame-level model every cycle, plus literal
//                frame patterns. Honours SERIAL_TX_PARITY_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_frame_tx;

    localparam int N = 8;
    localparam int C = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int F = N + 3;
    localparam logic [15:0] c_EXP_A5 = 16'b10101001010;
    localparam logic [15:0] c_EXP_01_MSB = 16'b11100000000;
    localparam logic [15:0] c_EXP_01_LSB = 16'b11000000010;
    localparam logic [15:0] c_EXP_07 = 16'b11111000000;
    localparam logic [15:0] c_EXP_3C = 16'b10001111000;
    localparam logic [15:0] c_EXP_C3 = 16'b10110000110;
`else
    localparam int F = N + 2;
    localparam logic [15:0] c_EXP_A5 = 16'b1101001010;
    localparam logic [15:0] c_EXP_01_MSB = 16'b1100000000;
    localparam logic [15:0] c_EXP_01_LSB = 16'b1000000010;
    localparam logic [15:0] c_EXP_07 = 16'b1111000000;
    localparam logic [15:0] c_EXP_3C = 16'b1001111000;
    localparam logic [15:0] c_EXP_C3 = 16'b1110000110;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_frame_tx_if #(.NUM_BITS(N)) bus0 ();
    serial_frame_tx_if #(.NUM_BITS(N)) bus1 ();

    assign bus0.tx_data  = tx_data;
    assign bus0.tx_valid = tx_valid;
    assign bus1.tx_data  = tx_data;
    assign bus1.tx_valid = tx_valid;

    serial_frame_tx #(.NUM_BITS(N), .SHIFT_MSB(1'b1), .CLKS_PER_BIT(C)) dut_msb (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );
    serial_frame_tx #(.NUM_BITS(N), .SHIFT_MSB(1'b0), .CLKS_PER_BIT(C)) dut_lsb (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    logic a_line [2];
    logic a_ready[2];
    logic a_busy [2];
    logic a_done [2];
    assign a_line[0]  = bus0.serial_out;
    assign a_line[1]  = bus1.serial_out;
    assign a_ready[0] = bus0.tx_ready;
    assign a_ready[1] = bus1.tx_ready;
    assign a_busy[0]  = bus0.tx_busy;
    assign a_busy[1]  = bus1.tx_busy;
    assign a_done[0]  = bus0.tx_done;
    assign a_done[1]  = bus1.tx_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: unit 0 sends MSB first, unit 1 LSB first.
    bit   m_busy[2] = '{0, 0};
    int   m_t[2]    = '{0, 0};
    logic m_line[2] = '{1'b1, 1'b1};
    logic m_done[2] = '{1'b0, 1'b0};
    logic m_bits[2][0:15];

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            m_done[u] = 1'b0;
            if (rst) begin
                m_busy[u] = 0;
                m_line[u] = 1'b1;
            end else if (!m_busy[u]) begin
                if (tx_valid) begin
                    m_bits[u][0] = 1'b0;
                    for (int i = 0; i < N; i++)
                        m_bits[u][1+i] = (u == 0) ? tx_data[N-1-i] : tx_data[i];
`ifdef SERIAL_TX_PARITY_EN
                    m_bits[u][N+1] = ^tx_data;
`endif
                    m_bits[u][F-1] = 1'b1;
                    m_busy[u] = 1;
                    m_t[u]    = 0;
                    m_line[u] = 1'b0;
                end
            end else begin
                m_t[u]++;
                if (m_t[u] == F * C) begin
                    m_busy[u] = 0;
                    m_done[u] = 1'b1;
                    m_line[u] = 1'b1;
                end else begin
                    m_line[u] = m_bits[u][m_t[u] / C];
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("serial_out[%0d]", u), 32'(a_line[u]), 32'(m_line[u]));
            chk($sformatf("tx_ready[%0d]", u), 32'(a_ready[u]), 32'(!m_busy[u]));
            chk($sformatf("tx_busy[%0d]", u), 32'(a_busy[u]), 32'(m_busy[u]));
            chk($sformatf("tx_done[%0d]", u), 32'(a_done[u]), 32'(m_done[u]));
        end
    end

    // Sends one word from a negedge; records the mid-bit line level of each
    // period (bit k in b[k]) and the cycle offset of tx_done after accept.
    task automatic send(input logic [7:0] d, input int pulse_j,
                        output logic [15:0] b0, output logic [15:0] b1, output int dj);
        int w;
        b0 = '0;
        b1 = '0;
        dj = -1;
        tx_data  = d;
        tx_valid = 1'b1;
        w = 0;
        while (!bus0.tx_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", 32'(bus0.tx_ready), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        for (int j = 0; j <= F * C + 2; j++) begin
            if ((j % C) == 1 && (j / C) < F) begin
                b0[j/C] = bus0.serial_out;
                b1[j/C] = bus1.serial_out;
            end
            if (bus0.tx_done && dj < 0) dj = j;
            if (j == pulse_j) begin
                tx_data  = ~d;
                tx_valid = 1'b1;
            end else if (j == pulse_j + 1) begin
                tx_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    logic [15:0] b0, b1;
    int          dj;
    int          second_j, ones_run, ready_hi, done_cnt, w;

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_serial", 32'(bus0.serial_out), 32'd1);
        chk("reset_busy", 32'(bus0.tx_busy), 32'd0);
        chk("reset_ready", 32'(bus0.tx_ready), 32'd1);
        chk("reset_done", 32'(bus0.tx_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        send(8'hA5, -1, b0, b1, dj);
        chk("a5_msb_bits", 32'(b0), 32'(c_EXP_A5));
        chk("a5_lsb_bits", 32'(b1), 32'(c_EXP_A5));
        chk("a5_done_at", 32'(dj), 32'(F * C));

        send(8'h01, -1, b0, b1, dj);
        chk("01_msb_bits", 32'(b0), 32'(c_EXP_01_MSB));
        chk("01_lsb_bits", 32'(b1), 32'(c_EXP_01_LSB));

        send(8'h07, -1, b0, b1, dj);
        chk("07_msb_bits", 32'(b0), 32'(c_EXP_07));
        chk("07_done_at", 32'(dj), 32'(F * C));

        // Back-to-back: valid held high across two frames
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        w = 0;
        while (!bus0.tx_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        tx_data  = 8'hAA;
        second_j = -1;
        ones_run = 0;
        ready_hi = 0;
        for (int j = 0; j < 3 * F * C; j++) begin
            if (j < F * C && bus0.tx_ready) ready_hi++;
            if (j >= F * C && !bus0.serial_out) begin
                second_j = j;
                tx_valid = 1'b0;
                break;
            end
            if (j >= (F - 1) * C && bus0.serial_out) ones_run++;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        chk("b2b_ready_low", 32'(ready_hi), 32'd0);
        chk("b2b_second_accept", 32'(second_j), 32'(F * C + 1));
        chk("b2b_gap_high", 32'(ones_run), 32'(C + 1));
        repeat (F * C + 2) @(negedge clk);

        // Busy: data change and valid pulse mid-frame are ignored
        send(8'h3C, 13, b0, b1, dj);
        chk("busy_3c_bits", 32'(b0), 32'(c_EXP_3C));

        // Reset during the 3rd data bit
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        w = 0;
        while (!bus0.tx_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_serial", 32'(bus0.serial_out), 32'd1);
        chk("rst_mid_busy", 32'(bus0.tx_busy), 32'd0);
        chk("rst_mid_ready", 32'(bus0.tx_ready), 32'd1);
        rst = 1'b0;
        done_cnt = 0;
        for (int j = 0; j < F * C + 10; j++) begin
            if (bus0.tx_done || bus1.tx_done) done_cnt++;
            @(negedge clk);
        end
        chk("rst_mid_no_done", 32'(done_cnt), 32'd0);

        send(8'hC3, -1, b0, b1, dj);
        chk("post_rst_c3_bits", 32'(b0), 32'(c_EXP_C3));
        chk("post_rst_done_at", 32'(dj), 32'(F * C));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/serial_frame_tx.md
# serial_frame_tx

Parallel-to-serial framed transmitter: accepts an NUM_BITS-wide word over a valid/ready handshake and shifts it out on a single line as start bit, data bits, optional parity bit, and stop bit, each held for a fixed number of clocks. It is the transmit end of the team's serial link and feeds the serial-to-parallel receive path. Its idle line level is high, which matches the receiver's all-ones reset state.

## Interface
- NUM_BITS, 8, data bits per frame (≥2)
- SHIFT_MSB, 1, 1 = MSB transmitted first, 0 = LSB first
- CLKS_PER_BIT, 10, clock cycles each line bit is held (≥2)

- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- tx_data  input  NUM_BITS  word to send, sampled only on an accepting edge
- tx_valid  input  1  producer has a word
- tx_ready  output  1  block can accept; high only in IDLE (decoded from state)
- serial_out  output  1  registered serial line; idle high
- tx_busy  output  1  high in every non-IDLE state
- tx_done  output  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- Accept: tx_valid && tx_ready at a rising edge. On that edge the block:
  - loads tx_data into the shift register;
  - clears the bit-period counter and bit index;
  - moves to START and sets serial_out to 0.
- Bit-period counter: ceil(log2(CLKS_PER_BIT)) bits. It counts 0..CLKS_PER_BIT-1. On the edge where it equals CLKS_PER_BIT-1, the counter wraps to 0 and the line advances to the next bit.
- START → DATA: serial_out is driven to the first data bit, which is data[NUM_BITS-1] if SHIFT_MSB=1, else data[0]. The shift register shifts toward the output end.
- DATA: the bit index counts 0..NUM_BITS-1. After the last bit period the block goes to PARITY (macro defined) or STOP, and serial_out is driven accordingly (parity bit, or 1 for STOP).
- STOP: serial_out = 1 for CLKS_PER_BIT cycles. At the end of the period:
  - next state is IDLE;
  - tx_done = 1 for exactly one cycle;
  - serial_out stays 1.
- tx_valid while busy: ignored, because tx_ready = 0. tx_data changes after accept do not affect the frame in flight.
- Reset values: state IDLE, serial_out = 1, tx_busy = 0, tx_done = 0, tx_ready = 1 (once the state is IDLE), shift register all ones, counters 0.
- Reset mid-frame: the frame is aborted. serial_out = 1 from the reset edge onward. No tx_done is generated.
- rst has priority over accept on the same edge.

## Timing
- Accept on edge E0. serial_out changes at the following edges:
  - 0 at E0;
  - first data bit at E0 + CLKS_PER_BIT;
  - data bit k at E0 + (k+1)·CLKS_PER_BIT;
  - stop bit at E0 + (NUM_BITS+1)·CLKS_PER_BIT, or E0 + (NUM_BITS+2)·CLKS_PER_BIT when parity is enabled.
- Frame ends at edge EF = E0 + F·CLKS_PER_BIT, with F = NUM_BITS+2 (or NUM_BITS+3 with parity). tx_done is high for the cycle [EF, EF+1).
- Back-to-back: tx_ready rises at EF. The earliest next accept is edge EF+1, so the stop level lasts CLKS_PER_BIT+1 cycles minimum.
- tx_busy is high from E0 to EF.

## Configuration
- SERIAL_TX_PARITY_EN:
  - Defined: the PARITY state is compiled in. One extra bit period follows the last data bit, carrying even parity (XOR of all NUM_BITS data bits).
  - Undefined: no PARITY state; STOP follows DATA directly. Frame length is NUM_BITS+2 bit periods.

## Test plan
- Basic frame. Setup: reset 2 cycles, NUM_BITS=8, CLKS_PER_BIT=4, SHIFT_MSB=1, no parity. Stimulus: accept 0xA5. Required response: serial_out = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done pulses at E0+40; tx_busy high for 40 cycles.
- LSB first. Setup: SHIFT_MSB=0. Stimulus: send 0x01. Required response: after the start bit, data bits are 1,0,0,0,0,0,0,0, then stop 1.
- Parity. Setup: SERIAL_TX_PARITY_EN defined. Stimulus: send 0x07. Required response: parity bit = 1 in the bit period after the data; tx_done at E0+44 (CLKS_PER_BIT=4).
- Back-to-back. Stimulus: hold tx_valid high with 0x55 then 0xAA. Required response: tx_ready is low throughout frame 1; the second accept occurs at EF+1; the line is high for exactly 5 cycles between frames.
- Busy. Stimulus: change tx_data and pulse tx_valid mid-frame. Required response: no accept, and frame bits are unchanged.
- Reset mid-frame. Stimulus: assert rst during the 3rd data bit. Required response: serial_out = 1, tx_busy = 0, no tx_done; a new frame sent afterward is correct.
